counter_trigger_sequencer: RTL and testbench
============================================

COUNTER_TRIGGER_SEQUENCER -- requirements
Module: counter_trigger_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, the width of last_counter and reference_counter.
REQ-002 SHALL have parameter TIMER_WIDTH, default 32, the width of hold_cycles, arm_timeout and the internal timers.
REQ-003 SHALL have parameter TRIG_COUNT_WIDTH, default 16, the width of trigger_count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: block enable; low forces IDLE.
REQ-007 SHALL have port start, input, 1 bit: start request pulse.
REQ-008 SHALL have port stop, input, 1 bit: abort request, level.
REQ-009 SHALL have port continuous, input, 1 bit: re-arm after each trigger cycle.
REQ-010 SHALL have port hold_cycles, input, TIMER_WIDTH bits: number of cycles trigger is held high before reset.
REQ-011 SHALL have port arm_timeout, input, TIMER_WIDTH bits: maximum number of cycles in WAIT_TRIG; 0 disables the timeout.
REQ-012 SHALL have port last_counter, input, COUNTER_WIDTH bits: last full period from the counter trigger.
REQ-013 SHALL have port trigger, input, 1 bit: trigger from the counter trigger.
REQ-014 SHALL have port trigger_armed, input, 1 bit: arming status from the counter trigger.
REQ-015 SHALL have port trigger_arm, output, 1 bit: single-cycle arm pulse.
REQ-016 SHALL have port trigger_reset, output, 1 bit: single-cycle trigger reset pulse.
REQ-017 SHALL have port reference_counter, output, COUNTER_WIDTH bits: averaged period.
REQ-018 SHALL have port ref_valid, output, 1 bit: reference_counter holds a valid average.
REQ-019 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 SHALL have port timeout_error, output, 1 bit: sticky flag set on arm timeout.
REQ-021 SHALL have port trigger_count, output, TRIG_COUNT_WIDTH bits: number of completed trigger cycles.

Function
REQ-022 SHALL register last_counter into prev_counter every cycle; a new sample is detected when last_counter != prev_counter and last_counter != 0.
REQ-023 SHALL, on the first new sample after reset or enable low, load all 4 averaging slots with that sample and set ref_valid.
REQ-024 SHALL, on each later new sample, shift it into a 4-deep slot window and drop the oldest.
REQ-025 SHALL compute the sum in COUNTER_WIDTH+2 bits and register reference_counter = floor(sum/4), 2 cycles after the last_counter change.
REQ-026 SHALL implement states IDLE, WAIT_REF, ARM, WAIT_TRIG, HOLD, RESET_TRIG.
REQ-027 SHALL, in IDLE on start=1, go to ARM if ref_valid=1 or WAIT_REF otherwise; start also clears timeout_error and trigger_count.
REQ-028 SHALL leave WAIT_REF for ARM in the first cycle ref_valid=1.
REQ-029 SHALL assert trigger_arm for exactly 1 cycle in ARM, then go to WAIT_TRIG and load the timeout timer with arm_timeout.
REQ-030 SHALL, in WAIT_TRIG, go to HOLD on trigger=1 and trigger_armed=1 and load the hold timer with hold_cycles.
REQ-031 SHALL, in WAIT_TRIG with arm_timeout != 0, go to RESET_TRIG when the timer reaches 0 with no trigger, and set timeout_error.
REQ-032 SHALL decrement the hold timer in HOLD and go to RESET_TRIG when it is 0; hold_cycles=0 gives a 1-cycle HOLD.
REQ-033 SHALL assert trigger_reset for exactly 1 cycle in RESET_TRIG, and increment trigger_count (saturating) only when the state was entered from HOLD.
REQ-034 SHALL leave RESET_TRIG for ARM when continuous=1, stop=0 and no timeout occurred; otherwise it SHALL go to IDLE.
REQ-035 SHALL, on stop=1 in WAIT_REF, go to IDLE, and on stop=1 in ARM, WAIT_TRIG or HOLD, go to RESET_TRIG; stop takes priority over trigger and timers in the same cycle.
REQ-036 SHALL, on enable=0, go to IDLE next cycle, clear the averaging slots and ref_valid, and keep trigger_arm and trigger_reset low.
REQ-037 SHALL ignore start while not in IDLE.

Reset
REQ-038 SHALL, while aresetn=0, set the state to IDLE and clear all outputs, slots, timers and prev_counter to 0.

Verification
REQ-039 SHALL cover: last_counter 0->1000 -> ref_valid=1 and reference_counter=1000 two cycles later; then 1004, 1008, 1012 -> reference_counter=1006.
REQ-040 SHALL cover: ref_valid=1, start, trigger rises 5 cycles after arm, hold_cycles=3 -> 1 arm pulse, HOLD for 4 cycles, 1 reset pulse, trigger_count=1, IDLE.
REQ-041 SHALL cover: continuous=1, 3 trigger events -> 3 arm and 3 reset pulses, trigger_count=3, busy stays 1.
REQ-042 SHALL cover: arm_timeout=10 with no trigger -> RESET_TRIG 10 cycles after WAIT_TRIG entry, timeout_error=1, IDLE even with continuous=1.
REQ-043 SHALL cover: stop in HOLD -> 1 reset pulse then IDLE; enable=0 mid-WAIT_TRIG -> IDLE and ref_valid=0.
REQ-044 SHALL cover: aresetn low during HOLD -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/counter_trigger_sequencer.sv
// Sequencer for an external counter trigger: averages the last four measured
// periods and runs the arm / wait / hold / reset handshake around each trigger.
module counter_trigger_sequencer #(
  parameter int COUNTER_WIDTH    = 32,
  parameter int TIMER_WIDTH      = 32,
  parameter int TRIG_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        continuous,
  input  logic [TIMER_WIDTH-1:0]      hold_cycles,
  input  logic [TIMER_WIDTH-1:0]      arm_timeout,
  input  logic [COUNTER_WIDTH-1:0]    last_counter,
  input  logic                        trigger,
  input  logic                        trigger_armed,
  output logic                        trigger_arm,
  output logic                        trigger_reset,
  output logic [COUNTER_WIDTH-1:0]    reference_counter,
  output logic                        ref_valid,
  output logic                        busy,
  output logic                        timeout_error,
  output logic [TRIG_COUNT_WIDTH-1:0] trigger_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT_REF, ARM, WAIT_TRIG, HOLD, RESET_TRIG
  } state_t;

  logic [COUNTER_WIDTH-1:0]    prev_q;
  logic [COUNTER_WIDTH-1:0]    slot_q [4];
  logic                        slots_valid_q;
  logic [COUNTER_WIDTH-1:0]    ref_q;
  logic                        ref_valid_q;
  logic [COUNTER_WIDTH+1:0]    sum;
  logic                        new_sample;

  state_t                      state_q, state_d;
  logic [TIMER_WIDTH-1:0]      timer_q, timer_d;
  logic                        timeout_en_q, timeout_en_d;
  logic                        timeout_error_q, timeout_error_d;
  logic [TRIG_COUNT_WIDTH-1:0] count_q, count_d;

  assign new_sample = (last_counter != prev_q) && (last_counter != '0);
  assign sum = {2'b00, slot_q[0]} + {2'b00, slot_q[1]} + {2'b00, slot_q[2]} + {2'b00, slot_q[3]};

  // ref_valid follows slots_valid by one cycle so it rises together with the first average.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q        <= '0;
      slots_valid_q <= 1'b0;
      ref_q         <= '0;
      ref_valid_q   <= 1'b0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      prev_q <= last_counter;
      if (!enable) begin
        slots_valid_q <= 1'b0;
        ref_valid_q   <= 1'b0;
        for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      end else begin
        if (new_sample) begin
          slots_valid_q <= 1'b1;
          slot_q[0]     <= last_counter;
          for (int i = 1; i < 4; i++)
            slot_q[i] <= slots_valid_q ? slot_q[i-1] : last_counter;
        end
        ref_valid_q <= slots_valid_q;
        ref_q       <= sum[COUNTER_WIDTH+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      timeout_en_q    <= 1'b0;
      timeout_error_q <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      timeout_en_q    <= timeout_en_d;
      timeout_error_q <= timeout_error_d;
      count_q         <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    timeout_en_d    = timeout_en_q;
    timeout_error_d = timeout_error_q;
    count_d         = count_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d         = ref_valid_q ? ARM : WAIT_REF;
          timeout_error_d = 1'b0;
          count_d         = '0;
        end
        WAIT_REF: begin
          if (stop)             state_d = IDLE;
          else if (ref_valid_q) state_d = ARM;
        end
        ARM: begin
          if (stop) begin
            state_d = RESET_TRIG;
          end else begin
            state_d      = WAIT_TRIG;
            timer_d      = arm_timeout;
            timeout_en_d = (arm_timeout != '0);
          end
        end
        WAIT_TRIG: begin
          // Exit on the tenth cycle for arm_timeout=10, hence the compare against 1.
          if (stop) begin
            state_d = RESET_TRIG;
          end else if (trigger && trigger_armed) begin
            state_d = HOLD;
            timer_d = hold_cycles;
          end else if (timeout_en_q && (timer_q <= TIMER_WIDTH'(1))) begin
            state_d         = RESET_TRIG;
            timeout_error_d = 1'b1;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
        HOLD: begin
          if (stop || (timer_q == '0)) begin
            state_d = RESET_TRIG;
            if (count_q != '1) count_d = count_q + TRIG_COUNT_WIDTH'(1);
          end else begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
        RESET_TRIG: begin
          state_d = (continuous && !stop && !timeout_error_q) ? ARM : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign trigger_arm       = enable && (state_q == ARM);
  assign trigger_reset     = enable && (state_q == RESET_TRIG);
  assign busy              = (state_q != IDLE);
  assign reference_counter = ref_q;
  assign ref_valid         = ref_valid_q;
  assign timeout_error     = timeout_error_q;
  assign trigger_count     = count_q;

endmodule

// File: tb/tb_counter_trigger_sequencer.sv
// Directed bench for counter_trigger_sequencer: averaging, single and continuous
// trigger cycles, timeout, stop, enable drop and asynchronous reset.
module tb_counter_trigger_sequencer;

  logic        clk = 1'b0;
  logic        aresetn, enable, start, stop, continuous;
  logic [31:0] hold_cycles, arm_timeout, last_counter;
  logic        trigger, trigger_armed;
  logic        trigger_arm, trigger_reset, ref_valid, busy, timeout_error;
  logic [31:0] reference_counter;
  logic [15:0] trigger_count;

  int tests_run = 0;
  int tests_failed = 0;
  int arm_cnt = 0;
  int rst_cnt = 0;
  int arm_base, rst_base;

  counter_trigger_sequencer dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .start(start), .stop(stop),
    .continuous(continuous), .hold_cycles(hold_cycles), .arm_timeout(arm_timeout),
    .last_counter(last_counter), .trigger(trigger), .trigger_armed(trigger_armed),
    .trigger_arm(trigger_arm), .trigger_reset(trigger_reset),
    .reference_counter(reference_counter), .ref_valid(ref_valid), .busy(busy),
    .timeout_error(timeout_error), .trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trigger_arm)   arm_cnt++;
    if (trigger_reset) rst_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("[TB] %s ok value=%0d", tag, got);
    end
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    hold_cycles = 0; arm_timeout = 0; last_counter = 0;
    trigger = 1'b0; trigger_armed = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ref_valid", ref_valid, 0);
    chk("rst_ref", reference_counter, 0);
    chk("rst_arm_reset", {trigger_arm, trigger_reset}, 0);
    aresetn = 1'b1; enable = 1'b1;
    tick();

    // Averaging: first sample fills all slots, later samples slide in.
    last_counter = 1000;
    tick();
    chk("avg_valid_1cyc", ref_valid, 0);
    tick();
    chk("avg_valid_2cyc", ref_valid, 1);
    chk("avg_first", reference_counter, 1000);
    last_counter = 1004; tick();
    last_counter = 1008; tick();
    last_counter = 1012; tick();
    chk("avg_partial", reference_counter, 1003);
    tick();
    chk("avg_window", reference_counter, 1006);

    // Single trigger cycle, hold_cycles=3.
    hold_cycles = 3; trigger_armed = 1'b1;
    arm_base = arm_cnt; rst_base = rst_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("single_arm", trigger_arm, 1);
    chk("single_busy", busy, 1);
    tick();
    chk("single_arm_gone", trigger_arm, 0);
    repeat (4) tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("hold_c1", trigger_reset, 0);
    tick(); tick(); tick();
    chk("hold_c4", trigger_reset, 0);
    tick();
    chk("single_reset", trigger_reset, 1);
    chk("single_count", trigger_count, 1);
    tick();
    chk("single_idle", busy, 0);
    chk("single_pulses", {arm_cnt - arm_base, rst_cnt - rst_base}, {32'd1, 32'd1});

    // Continuous mode, three events with hold_cycles=0.
    hold_cycles = 0; continuous = 1'b1;
    arm_base = arm_cnt; rst_base = rst_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("cont_count_cleared", trigger_count, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      trigger = 1'b1; tick(); trigger = 1'b0;
      chk("cont_busy_hold", busy, 1);
      if (k == 2) continuous = 1'b0;
      tick();
      chk("cont_reset", trigger_reset, 1);
      if (k < 2) begin
        tick();
        chk("cont_rearm", {busy, trigger_arm}, 2'b11);
      end
    end
    chk("cont_count", trigger_count, 3);
    tick();
    chk("cont_pulses", {arm_cnt - arm_base, rst_cnt - rst_base}, {32'd3, 32'd3});

    // Arm timeout of 10 cycles with no trigger; continuous must not re-arm.
    continuous = 1'b1; arm_timeout = 10;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (9) tick();
    chk("tmo_wait9", {trigger_reset, timeout_error}, 0);
    tick();
    chk("tmo_reset", {trigger_reset, timeout_error}, 2'b11);
    chk("tmo_count", trigger_count, 0);
    tick();
    chk("tmo_idle", {busy, trigger_arm}, 0);

    // Stop during HOLD: one reset pulse then IDLE despite continuous.
    arm_timeout = 0; hold_cycles = 20;
    rst_base = rst_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("stop_err_cleared", timeout_error, 0);
    tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    stop = 1'b1; tick();
    chk("stop_reset", trigger_reset, 1);
    tick(); stop = 1'b0;
    chk("stop_idle", busy, 0);
    tick();
    chk("stop_pulses", rst_cnt - rst_base, 1);

    // Enable drop during WAIT_TRIG.
    continuous = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("en_waiting", busy, 1);
    enable = 1'b0; tick();
    chk("en_idle", {busy, ref_valid, trigger_arm, trigger_reset}, 0);
    enable = 1'b1;

    // Asynchronous reset during HOLD.
    last_counter = 2000; tick(); tick();
    chk("reavg", {ref_valid, reference_counter}, {1'b1, 32'd2000});
    hold_cycles = 50;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst", {busy, ref_valid, reference_counter, timeout_error, trigger_count,
                      trigger_arm, trigger_reset}, 0);

    // WAIT_REF path: start without a reference, then a sample arrives.
    last_counter = 0;
    tick();
    aresetn = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("wref_busy", {busy, trigger_arm}, 2'b10);
    last_counter = 3000;
    tick(); tick();
    chk("wref_still_waiting", trigger_arm, 0);
    tick();
    chk("wref_arm", {trigger_arm, reference_counter}, {1'b1, 32'd3000});
    stop = 1'b1; tick();
    chk("wref_stop_reset", trigger_reset, 1);
    tick(); stop = 1'b0;
    chk("wref_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
